// File: rtl/lm07_temp_reader_if.sv
// Bus between the LM07 reader and the sensor/display side: serial link plus display outputs.
// The master modport belongs to the reader; the slave modport is the sensor and display view.
interface lm07_temp_reader_if;
    logic       SIO;
    logic       CS;
    logic       SCK;
    logic [7:0] data;
    logic [1:0] disp;
    logic [6:0] disp_seg_LSB;
    logic [6:0] disp_seg_MSB;

    modport master (
        input  SIO,
        output CS,
        output SCK,
        output data,
        output disp,
        output disp_seg_LSB,
        output disp_seg_MSB
    );

    modport slave (
        output SIO,
        input  CS,
        input  SCK,
        input  data,
        input  disp,
        input  disp_seg_LSB,
        input  disp_seg_MSB
    );
endinterface

// File: rtl/lm07_temp_reader.sv
// SPI master that repeatedly reads 8-bit temperature frames from an LM07 sensor.
// The last complete frame is shown as two saturated decimal digits on a 7-segment display.
module lm07_temp_reader #(
    parameter int IDLE_CYC = 8,
    parameter int SCK_DIV  = 4,
    parameter int NBITS    = 8
) (
    input  logic                 RSTN,
    input  logic                 SYSCLK,
    lm07_temp_reader_if.master   bus
);

    localparam int IDLE_W = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
    localparam int PH_W   = (SCK_DIV  > 1) ? $clog2(SCK_DIV)  : 1;
    localparam int BIT_W  = (NBITS    > 1) ? $clog2(NBITS)    : 1;

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);
    localparam logic [PH_W-1:0]   PH_RISE   = PH_W'(SCK_DIV / 2 - 1);
    localparam logic [PH_W-1:0]   PH_HIGH   = PH_W'(SCK_DIV / 2);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SCK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NBITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [IDLE_W-1:0] idle_cnt;
    logic [PH_W-1:0]   phase;
    logic [BIT_W-1:0]  bit_cnt;
    logic [7:0]        sr;
    logic [7:0]        data_reg;
    logic [1:0]        disp_reg;
    logic              idle_over;
    logic              frame_over;

    logic [7:0]        clamped;
    logic [3:0]        tens;
    logic [3:0]        units;

    assign idle_over  = (idle_cnt == IDLE_LAST);
    assign frame_over = (phase == PH_LAST) && (bit_cnt == BIT_LAST);

    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (idle_over)  next_state = ST_SHIFT;
            ST_SHIFT: if (frame_over) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // CS and SCK come straight from the state register, so both fall back to idle
    // levels in the same instant and CS can never move while SCK is high.
    always_comb begin
        bus.CS  = 1'b1;
        bus.SCK = 1'b0;
        if (state == ST_SHIFT) begin
            bus.CS  = 1'b0;
            bus.SCK = (phase >= PH_HIGH);
        end
    end

    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            idle_cnt <= '0;
            phase    <= '0;
            bit_cnt  <= '0;
        end else begin
            idle_cnt <= (state == ST_IDLE && !idle_over) ? idle_cnt + 1'b1 : '0;
            if (state == ST_SHIFT) begin
                phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
                if (phase == PH_LAST) begin
                    bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
                end
            end else begin
                phase   <= '0;
                bit_cnt <= '0;
            end
        end
    end

    // SIO is sampled on the SYSCLK edge that raises SCK; the sensor changed it on the
    // previous SCK fall (or when CS dropped), so it has had half an SCK period to settle.
    // The frame is published on entry to DONE so it appears together with the CS rise.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            sr       <= '0;
            data_reg <= '0;
            disp_reg <= 2'b00;
        end else begin
            if (state == ST_SHIFT && phase == PH_RISE) begin
                sr <= {sr[6:0], bus.SIO};
            end
            if (state == ST_SHIFT && frame_over) begin
                data_reg <= sr;
                disp_reg <= 2'b11;
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Two digits can only show up to 99, so larger readings saturate there.
    always_comb begin
        clamped = (data_reg > 8'd99) ? 8'd99 : data_reg;
        tens    = 4'(clamped / 8'd10);
        units   = 4'(clamped % 8'd10);
    end

    assign bus.data         = data_reg;
    assign bus.disp         = disp_reg;
    assign bus.disp_seg_MSB = seg7(tens);
    assign bus.disp_seg_LSB = seg7(units);

endmodule

// File: tb/tb_lm07_temp_reader.sv
// Directed bench for lm07_temp_reader: an LM07 model drives a fixed byte on SIO and
// frame timing, decoded data, segment patterns and async reset behaviour are checked.
module tb_lm07_temp_reader;

    logic SYSCLK = 1'b0;
    logic RSTN   = 1'b0;

    always #5 SYSCLK = ~SYSCLK;

    lm07_temp_reader_if bus ();

    lm07_temp_reader dut (
        .RSTN   (RSTN),
        .SYSCLK (SYSCLK),
        .bus    (bus)
    );

    int         tests = 0;
    int         fails = 0;
    logic [7:0] sensor_byte;
    int         bit_idx;
    bit         active;

    // Sensor model: MSB appears when CS drops, each later bit on an SCK fall.
    initial begin
        bus.SIO = 1'b0;
        active  = 1'b0;
        bit_idx = 0;
        forever begin
            @(negedge bus.CS or posedge bus.CS or negedge bus.SCK);
            if (bus.CS) begin
                active = 1'b0;
            end else if (!active) begin
                active  = 1'b1;
                bit_idx = 7;
                bus.SIO = sensor_byte[7];
            end else if (!bus.SCK && bit_idx > 0) begin
                bit_idx = bit_idx - 1;
                bus.SIO = sensor_byte[bit_idx];
            end
        end
    end

    logic prev_cs    = 1'b1;
    logic prev_sck   = 1'b0;
    int   violations = 0;

    always @(negedge SYSCLK) begin
        if (prev_cs && bus.CS && (bus.SCK !== prev_sck)) violations++;
        if (prev_sck && bus.SCK && (bus.CS !== prev_cs)) violations++;
        prev_cs  = bus.CS;
        prev_sck = bus.SCK;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_display(input string tag, input logic [7:0] exp_data,
                                 input logic [6:0] exp_msb, input logic [6:0] exp_lsb);
        check_output({tag, "_data"}, 32'(bus.data), 32'(exp_data));
        check_output({tag, "_disp"}, 32'(bus.disp), 32'(2'b11));
        check_output({tag, "_msb"},  32'(bus.disp_seg_MSB), 32'(exp_msb));
        check_output({tag, "_lsb"},  32'(bus.disp_seg_LSB), 32'(exp_lsb));
    endtask

    // Counts negedge samples until CS is seen rising; 0 means it never did.
    task automatic wait_frame(output int cycles);
        logic prev;
        prev   = bus.CS;
        cycles = 0;
        for (int i = 1; i <= 120; i++) begin
            @(negedge SYSCLK);
            if (!prev && bus.CS) begin
                cycles = i;
                return;
            end
            prev = bus.CS;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_cs"},   32'(bus.CS), 32'(1'b1));
        check_output({tag, "_sck"},  32'(bus.SCK), 32'(1'b0));
        check_output({tag, "_data"}, 32'(bus.data), 32'(8'h00));
        check_output({tag, "_disp"}, 32'(bus.disp), 32'(2'b00));
        check_output({tag, "_msb"},  32'(bus.disp_seg_MSB), 32'(7'h3F));
        check_output({tag, "_lsb"},  32'(bus.disp_seg_LSB), 32'(7'h3F));
    endtask

    initial begin
        int   cycles;
        logic exp_cs;
        logic exp_sck;
        bit   found;

        sensor_byte = 8'h19;
        RSTN        = 1'b0;
        repeat (3) @(negedge SYSCLK);
        check_reset_outputs("reset");

        // First frame after release, checked cycle by cycle.
        RSTN = 1'b1;
        #1;
        for (int k = 1; k <= 41; k++) begin
            if (k > 1) @(negedge SYSCLK);
            exp_cs  = (k <= 8) || (k == 41);
            exp_sck = (k >= 9) && (k <= 40) && (((k - 9) % 4) >= 2);
            check_output($sformatf("cs_c%0d", k),  32'(bus.CS),  32'(exp_cs));
            check_output($sformatf("sck_c%0d", k), 32'(bus.SCK), 32'(exp_sck));
            if (k == 40) check_output("data_before_done", 32'(bus.data), 32'(8'h00));
        end
        check_display("frame_19", 8'h19, 7'h5B, 7'h6D);

        sensor_byte = 8'h00;
        wait_frame(cycles);
        check_output("period_00", 32'(cycles), 32'd41);
        check_display("frame_00", 8'h00, 7'h3F, 7'h3F);

        sensor_byte = 8'h63;
        wait_frame(cycles);
        check_output("period_63", 32'(cycles), 32'd41);
        check_display("frame_63", 8'h63, 7'h6F, 7'h6F);

        sensor_byte = 8'hC8;
        wait_frame(cycles);
        check_output("period_c8", 32'(cycles), 32'd41);
        check_display("frame_c8", 8'hC8, 7'h6F, 7'h6F);

        // Reset dropped while SCK is high in the middle of a frame.
        sensor_byte = 8'h2A;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge SYSCLK);
            if (!bus.CS && bus.SCK) found = 1'b1;
        end
        check_output("found_sck_high", 32'(found), 32'(1'b1));
        RSTN = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(negedge SYSCLK);
        RSTN = 1'b1;
        wait_frame(cycles);
        check_output("period_after_reset", 32'(cycles), 32'd40);
        check_display("frame_2a", 8'h2A, 7'h66, 7'h5B);

        for (int f = 0; f < 5; f++) begin
            wait_frame(cycles);
            check_output($sformatf("run_period_%0d", f), 32'(cycles), 32'd41);
            check_output($sformatf("run_data_%0d", f), 32'(bus.data), 32'(8'h2A));
        end
        check_output("protocol_violations", 32'(violations), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
